// File: rtl/fix_if.sv
// Bundle of application, TOE and outbound-FIFO signals around the FIX session engine.
// Handshake: no backpressure anywhere; valid_i qualifies message_i in its cycle, and
// send_message_valid_o qualifies message_o in its cycle; the receiver must take every byte.
interface fix_if;
  logic       connect_i;
  logic [1:0] connect_to_host_i;
  logic       connected_i;
  logic [1:0] connected_host_addr_i;
  logic [7:0] message_i;
  logic       valid_i;
  logic       new_message_i;
  logic       connect_req_o;
  logic       disconnect_o;
  logic [1:0] connect_addr_o;
  logic [1:0] disconnect_host_num_o;
  logic       send_message_valid_o;
  logic [7:0] message_o;
  logic       message_received_o;

  modport master (
    output connect_i, connect_to_host_i, connected_i, connected_host_addr_i,
           message_i, valid_i, new_message_i,
    input  connect_req_o, disconnect_o, connect_addr_o, disconnect_host_num_o,
           send_message_valid_o, message_o, message_received_o
  );

  modport slave (
    input  connect_i, connect_to_host_i, connected_i, connected_host_addr_i,
           message_i, valid_i, new_message_i,
    output connect_req_o, disconnect_o, connect_addr_o, disconnect_host_num_o,
           send_message_valid_o, message_o, message_received_o
  );
endinterface

// File: rtl/fix_top.sv
// FIX session engine: connect/logon/heartbeat/logout sequencing, 22-byte outbound
// frame generator and a tag/value inbound parser that reports each completed message.
module fix_top #(
  parameter int HB_CYCLES    = 1000,
  parameter int CONN_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst,
  fix_if.slave       bus,
  output logic [2:0] state_dbg
);
  localparam logic [7:0] SOH  = 8'h01;
  localparam int         TMAX = (HB_CYCLES > CONN_TIMEOUT) ? HB_CYCLES : CONN_TIMEOUT;
  localparam int         TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CONN, S_SEND_LOGON, S_WAIT_LOGON, S_ACTIVE, S_SEND_LOGOUT, S_DISCONNECT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          logout_req;
  logic          tx_busy;
  logic [4:0]    tx_idx;
  logic [7:0]    tx_type;
  logic [7:0]    tx_sum;
  logic          tx_last;
  logic          logout_now;
  logic [7:0]    tx_byte;

  logic       in_value, first_val;
  logic [7:0] tag_a, tag_b, cap_type, rx_type;
  logic [1:0] tag_len;
  logic       c_in_value, c_first;
  logic [7:0] c_tag_a, c_tag_b, c_type;
  logic [1:0] c_tag_len;
  logic       tag_is_35, tag_is_10;

  assign state_dbg = state;

  // Checksum digits are valid at idx 18: tx_sum holds bytes 0..14 from idx 15 on.
  function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [7:0] t,
                                            input logic [7:0] sum);
    case (idx)
      5'd0:  frame_byte = "8";
      5'd1:  frame_byte = "=";
      5'd2:  frame_byte = "F";
      5'd3:  frame_byte = "I";
      5'd4:  frame_byte = "X";
      5'd5:  frame_byte = ".";
      5'd6:  frame_byte = "4";
      5'd7:  frame_byte = ".";
      5'd8:  frame_byte = "2";
      5'd10: frame_byte = "3";
      5'd11: frame_byte = "5";
      5'd12: frame_byte = "=";
      5'd13: frame_byte = t;
      5'd15: frame_byte = "1";
      5'd16: frame_byte = "0";
      5'd17: frame_byte = "=";
      5'd18: frame_byte = 8'h30 + (sum / 8'd100);
      5'd19: frame_byte = 8'h30 + ((sum / 8'd10) % 8'd10);
      5'd20: frame_byte = 8'h30 + (sum % 8'd10);
      default: frame_byte = SOH;
    endcase
  endfunction

  assign tx_byte    = frame_byte(tx_idx, tx_type, tx_sum);
  assign tx_last    = tx_busy && (tx_idx == 5'd21);
  assign logout_now = !bus.connect_i || logout_req ||
                      (bus.message_received_o && rx_type == "5");

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                     <= S_IDLE;
      timer                     <= '0;
      logout_req                <= 1'b0;
      tx_busy                   <= 1'b0;
      tx_idx                    <= '0;
      tx_type                   <= '0;
      tx_sum                    <= '0;
      bus.connect_req_o         <= 1'b0;
      bus.disconnect_o          <= 1'b0;
      bus.connect_addr_o        <= '0;
      bus.disconnect_host_num_o <= '0;
      bus.send_message_valid_o  <= 1'b0;
      bus.message_o             <= '0;
    end else begin
      bus.connect_req_o <= 1'b0;
      bus.disconnect_o  <= 1'b0;
      // Frame generator runs to completion regardless of state changes.
      if (tx_busy) begin
        bus.send_message_valid_o <= 1'b1;
        bus.message_o            <= tx_byte;
        if (tx_idx <= 5'd14) tx_sum <= tx_sum + tx_byte;
        if (tx_last) tx_busy <= 1'b0;
        else         tx_idx  <= tx_idx + 5'd1;
      end else begin
        bus.send_message_valid_o <= 1'b0;
        bus.message_o            <= '0;
      end

      if (state != S_IDLE && state != S_WAIT_CONN && !bus.connected_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (bus.connect_i && !tx_busy) begin
            bus.connect_addr_o <= bus.connect_to_host_i;
            bus.connect_req_o  <= 1'b1;
            timer              <= '0;
            state              <= S_WAIT_CONN;
          end
          S_WAIT_CONN: begin
            if (!bus.connect_i) state <= S_IDLE;
            else if (bus.connected_i && bus.connected_host_addr_i == bus.connect_addr_o) begin
              tx_busy <= 1'b1; tx_idx <= '0; tx_sum <= '0; tx_type <= "A";
              state   <= S_SEND_LOGON;
            end else if (timer == TW'(CONN_TIMEOUT - 1)) state <= S_IDLE;
            else timer <= timer + 1'b1;
          end
          S_SEND_LOGON: if (tx_last) begin
            timer <= '0;
            state <= S_WAIT_LOGON;
          end
          S_WAIT_LOGON: begin
            if (bus.message_received_o && rx_type == "A") begin
              timer      <= TW'(HB_CYCLES - 1);
              logout_req <= 1'b0;
              state      <= S_ACTIVE;
            end else if (!bus.connect_i || timer == TW'(CONN_TIMEOUT - 1)) begin
              tx_busy <= 1'b1; tx_idx <= '0; tx_sum <= '0; tx_type <= "5";
              state   <= S_SEND_LOGOUT;
            end else timer <= timer + 1'b1;
          end
          S_ACTIVE: begin
            if (bus.message_received_o && rx_type == "5") logout_req <= 1'b1;
            if (tx_busy) timer <= TW'(HB_CYCLES - 1);
            else if (logout_now) begin
              tx_busy <= 1'b1; tx_idx <= '0; tx_sum <= '0; tx_type <= "5";
              state   <= S_SEND_LOGOUT;
            end else if (timer == '0) begin
              tx_busy <= 1'b1; tx_idx <= '0; tx_sum <= '0; tx_type <= "0";
            end else timer <= timer - 1'b1;
          end
          S_SEND_LOGOUT: if (tx_last) state <= S_DISCONNECT;
          S_DISCONNECT: begin
            bus.disconnect_o          <= 1'b1;
            bus.disconnect_host_num_o <= bus.connect_addr_o;
            state                     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Parser view after an optional same-cycle clear by new_message_i.
  always_comb begin
    c_in_value = in_value;
    c_first    = first_val;
    c_tag_a    = tag_a;
    c_tag_b    = tag_b;
    c_tag_len  = tag_len;
    c_type     = cap_type;
    if (bus.new_message_i) begin
      c_in_value = 1'b0;
      c_first    = 1'b0;
      c_tag_a    = '0;
      c_tag_b    = '0;
      c_tag_len  = '0;
      c_type     = '0;
    end
  end

  assign tag_is_35 = (c_tag_len == 2'd2) && (c_tag_a == "3") && (c_tag_b == "5");
  assign tag_is_10 = (c_tag_len == 2'd2) && (c_tag_a == "1") && (c_tag_b == "0");

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_value               <= 1'b0;
      first_val              <= 1'b0;
      tag_a                  <= '0;
      tag_b                  <= '0;
      tag_len                <= '0;
      cap_type               <= '0;
      rx_type                <= '0;
      bus.message_received_o <= 1'b0;
    end else begin
      bus.message_received_o <= 1'b0;
      in_value  <= c_in_value;
      first_val <= c_first;
      tag_a     <= c_tag_a;
      tag_b     <= c_tag_b;
      tag_len   <= c_tag_len;
      cap_type  <= c_type;
      if (bus.valid_i) begin
        if (!c_in_value) begin
          if (bus.message_i == "=") begin
            in_value  <= 1'b1;
            first_val <= 1'b1;
          end else if (bus.message_i == SOH) begin
            tag_len <= '0;
          end else begin
            tag_a   <= c_tag_b;
            tag_b   <= bus.message_i;
            tag_len <= (c_tag_len == 2'd3) ? 2'd3 : c_tag_len + 2'd1;
          end
        end else if (bus.message_i == SOH) begin
          in_value  <= 1'b0;
          first_val <= 1'b0;
          tag_len   <= '0;
          if (tag_is_10) begin
            bus.message_received_o <= 1'b1;
            rx_type                <= c_type;
            cap_type               <= '0;
          end
        end else begin
          first_val <= 1'b0;
          if (c_first && tag_is_35) cap_type <= bus.message_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_fix_top.sv
// Randomized bench for fix_top: outbound frames are scored byte-by-byte against frames
// built from the FIX framing rules; pulses are counted and compared against expectations.
module tb_fix_top;
  localparam int HB = 200;
  localparam int CT = 128;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state_dbg;
  fix_if bus();

  fix_top #(.HB_CYCLES(HB), .CONN_TIMEOUT(CT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         err_cnt = 0;
  int         chk_cnt = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0, run = 0, tx_frames = 0, tx_start = 0;
  int         req_cnt = 0, disc_cnt = 0, rx_cnt = 0, rx_stamp = 0;
  logic [1:0] disc_host = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame built straight from the framing rules.
  function automatic bq_t make_frame(input logic [7:0] t);
    bq_t   q;
    string head, s35, s10;
    int    sum;
    head = "8=FIX.4.2";
    s35  = "35=";
    s10  = "10=";
    for (int i = 0; i < head.len(); i++) q.push_back(head[i]);
    q.push_back(8'h01);
    for (int i = 0; i < s35.len(); i++) q.push_back(s35[i]);
    q.push_back(t);
    q.push_back(8'h01);
    sum = 0;
    foreach (q[i]) sum += int'(q[i]);
    sum = sum % 256;
    for (int i = 0; i < s10.len(); i++) q.push_back(s10[i]);
    q.push_back(8'(48 + sum / 100));
    q.push_back(8'(48 + (sum / 10) % 10));
    q.push_back(8'(48 + sum % 10));
    q.push_back(8'h01);
    return q;
  endfunction

  task automatic expect_frame(input logic [7:0] t);
    bq_t f;
    f = make_frame(t);
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic       has;
    logic [7:0] e;
    cyc++;
    if (!rst) begin
      run = 0;
    end else begin
      if (bus.connect_req_o) req_cnt++;
      if (bus.disconnect_o) begin
        disc_cnt++;
        disc_host = bus.disconnect_host_num_o;
      end
      if (bus.message_received_o) begin
        rx_cnt++;
        rx_stamp = cyc;
      end
      if (bus.send_message_valid_o) begin
        if (run == 0) begin
          tx_frames++;
          tx_start = cyc;
        end
        run++;
        has = (exp_q.size() > 0);
        e   = has ? exp_q.pop_front() : 8'h00;
        check("tx_byte", {23'd0, 1'b1, bus.message_o}, {23'd0, has, e});
      end else if (run != 0) begin
        check("frame_len", run, 22);
        run = 0;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_inbound(input bq_t f, input bit first_new);
    foreach (f[i]) begin
      bus.valid_i       = 1'b1;
      bus.message_i     = f[i];
      bus.new_message_i = first_new && (i == 0);
      @(negedge clk);
      bus.valid_i       = 1'b0;
      bus.new_message_i = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || run != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    int n = 0;
    while (rx_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, rx_cnt, target);
  endtask

  task automatic wait_disc(input string tag, input int target, input int budget);
    int n = 0;
    while (disc_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, disc_cnt, target);
  endtask

  task automatic check_outputs_zero(input string p);
    check({p, "_req"},  bus.connect_req_o, 0);
    check({p, "_disc"}, bus.disconnect_o, 0);
    check({p, "_addr"}, bus.connect_addr_o, 0);
    check({p, "_host"}, bus.disconnect_host_num_o, 0);
    check({p, "_vld"},  bus.send_message_valid_o, 0);
    check({p, "_msg"},  bus.message_o, 0);
    check({p, "_rcv"},  bus.message_received_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] h;
    int         base, plen, gap;
    bq_t        f, part;
    logic [7:0] t;

    bus.connect_i = 1'b0; bus.connect_to_host_i = '0; bus.connected_i = 1'b0;
    bus.connected_host_addr_i = '0; bus.message_i = '0; bus.valid_i = 1'b0;
    bus.new_message_i = 1'b0;
    tick(3);
    check_outputs_zero("rst");
    rst = 1'b1;
    tick(2);

    // Wrong host address: ignored, timeout, retry request, no disconnect.
    h = 2'($urandom_range(0, 3));
    bus.connect_to_host_i     = h;
    bus.connect_i             = 1'b1;
    bus.connected_host_addr_i = h ^ 2'($urandom_range(1, 3));
    bus.connected_i           = 1'b1;
    tick(3);
    check("a_req", req_cnt, 1);
    check("a_addr", bus.connect_addr_o, h);
    tick(CT - 8);
    check("a_req_hold", req_cnt, 1);
    tick(12);
    check("a_req_retry", req_cnt, 2);
    check("a_no_disc", disc_cnt, 0);
    check("a_no_tx", tx_frames, 0);
    bus.connect_i   = 1'b0;
    bus.connected_i = 1'b0;
    tick(5);

    // Host 00: logon, peer logon, heartbeat, local logout.
    base = req_cnt;
    bus.connect_to_host_i = 2'b00;
    bus.connect_i         = 1'b1;
    tick(3);
    check("b_req", req_cnt, base + 1);
    check("b_addr", bus.connect_addr_o, 0);
    expect_frame("A");
    bus.connected_host_addr_i = 2'b00;
    bus.connected_i           = 1'b1;
    wait_drain("b_logon", 60);
    check("b_req_hold", req_cnt, base + 1);
    send_inbound(make_frame("A"), 1'b0);
    wait_rx("b_rx_logon", 1, 20);
    expect_frame("0");
    wait_drain("b_hb", HB + 60);
    gap = tx_start - rx_stamp;
    check("b_hb_gap_in_window", (gap >= HB && gap <= HB + 4), 1);
    bus.connect_i = 1'b0;
    expect_frame("5");
    wait_disc("b_disc", 1, 60);
    check("b_logout_drained", exp_q.size(), 0);
    check("b_disc_host", disc_host, 0);
    tick(5);
    check("b_idle_no_req", req_cnt, base + 1);
    bus.connected_i = 1'b0;
    tick(3);

    // Random host: peer sends Logout while ACTIVE.
    h = 2'($urandom_range(0, 3));
    bus.connect_to_host_i = h;
    bus.connect_i         = 1'b1;
    tick(2);
    expect_frame("A");
    bus.connected_host_addr_i = h;
    bus.connected_i           = 1'b1;
    wait_drain("p_logon", 60);
    send_inbound(make_frame("A"), 1'b0);
    wait_rx("p_rx_logon", 2, 20);
    expect_frame("5");
    send_inbound(make_frame("5"), 1'b0);
    wait_disc("p_disc", 2, 120);
    bus.connect_i   = 1'b0;
    bus.connected_i = 1'b0;
    check("p_disc_host", disc_host, h);
    check("p_rx_logout", rx_cnt, 3);
    tick(5);

    // Connection lost while waiting for peer Logon: no logout, no disconnect.
    bus.connect_to_host_i = 2'b01;
    bus.connect_i         = 1'b1;
    tick(2);
    expect_frame("A");
    bus.connected_host_addr_i = 2'b01;
    bus.connected_i           = 1'b1;
    wait_drain("c_logon", 60);
    bus.connected_i = 1'b0;
    tick(CT + 10);
    check("c_no_disc", disc_cnt, 2);
    bus.connect_i = 1'b0;
    tick(5);

    // Parser restart: partial message, then a full one beginning with new_message_i.
    base = rx_cnt;
    f    = make_frame("0");
    plen = $urandom_range(18, 20);
    part = {};
    for (int i = 0; i < plen; i++) part.push_back(f[i]);
    send_inbound(part, 1'b0);
    t = ($urandom_range(0, 1) == 0) ? 8'h30 : 8'h5A;
    send_inbound(make_frame(t), 1'b1);
    wait_rx("n_rx", base + 1, 20);
    tick(10);
    check("n_rx_once", rx_cnt, base + 1);

    // Reset in the middle of an outbound frame.
    bus.connect_to_host_i = 2'b11;
    bus.connect_i         = 1'b1;
    expect_frame("A");
    bus.connected_host_addr_i = 2'b11;
    bus.connected_i           = 1'b1;
    begin
      int n = 0;
      while (run < 10 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("d_mid_frame", run >= 10, 1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("d_rst");
    bus.connect_i   = 1'b0;
    bus.connected_i = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(10);
    check("end_exp_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
